// File: rtl/ds1302_write_if.sv
// Signal bundle between the DS1302 writer and the top level that owns sclk and the IO buffer.
interface ds1302_write_if;
  logic       en;
  logic       sclk;
  logic       ce;
  logic       ioDir;
  logic       dataOut;
  logic       busy;
  logic       done;
  logic [7:0] secIn;
  logic [7:0] minIn;
  logic [7:0] hrsIn;
  logic [7:0] dateIn;
  logic [7:0] monIn;
  logic [7:0] dayIn;
  logic [7:0] yrIn;

  modport master (
    input  en, sclk, secIn, minIn, hrsIn, dateIn, monIn, dayIn, yrIn,
    output ce, ioDir, dataOut, busy, done
  );

  modport slave (
    output en, sclk, secIn, minIn, hrsIn, dateIn, monIn, dayIn, yrIn,
    input  ce, ioDir, dataOut, busy, done
  );
endinterface

// File: rtl/ds1302_write.sv
// DS1302 time writer: clears write-protect, then writes sec..yr as single-byte 3-wire transactions.
// Optional macro DS1302_WP_RELOCK_EN appends a transaction that re-asserts write-protect.
module ds1302_write #(
  parameter int         GAP_EDGES = 2,
  parameter logic [7:0] CTRL_ADDR = 8'h8E
) (
  input  logic           clk,
  input  logic           rst,
  ds1302_write_if.master bus
);

  localparam int                GAP_W    = (GAP_EDGES > 1) ? $clog2(GAP_EDGES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_EDGES - 1);
`ifdef DS1302_WP_RELOCK_EN
  localparam logic [3:0]        LAST_TX  = 4'd8;
`else
  localparam logic [3:0]        LAST_TX  = 4'd7;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_H,
    SHIFT_L,
    STOP,
    GAP
  } state_t;

  state_t           state, state_n;
  logic             sclk_d;
  logic [15:0]      shift_q, shift_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [3:0]       tx_idx, tx_idx_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic [6:0][7:0]  snap, snap_n;
  logic             ce_q, ce_n;
  logic             io_dir_q, io_dir_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             rise, fall;
  logic [15:0]      first_word, next_word;

  // Words are stored {data, command} so that shifting right sends the command byte first, each LSB first.
  function automatic logic [15:0] tx_word(input logic [3:0] idx, input logic [6:0][7:0] s);
    logic [15:0] w;
    case (idx)
      4'd0:    w = {8'h00, CTRL_ADDR};
      4'd1:    w = {s[0], 8'h80};
      4'd2:    w = {s[1], 8'h82};
      4'd3:    w = {s[2], 8'h84};
      4'd4:    w = {s[3], 8'h86};
      4'd5:    w = {s[4], 8'h88};
      4'd6:    w = {s[5], 8'h8A};
      4'd7:    w = {s[6], 8'h8C};
`ifdef DS1302_WP_RELOCK_EN
      4'd8:    w = {8'h80, CTRL_ADDR};
`endif
      default: w = {8'h00, CTRL_ADDR};
    endcase
    return w;
  endfunction

  assign rise       = bus.sclk & ~sclk_d;
  assign fall       = ~bus.sclk & sclk_d;
  assign first_word = tx_word(4'd0, snap);
  assign next_word  = tx_word(tx_idx + 4'd1, snap);

  assign bus.ce      = ce_q;
  assign bus.ioDir   = io_dir_q;
  assign bus.dataOut = shift_q[0];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sclk_d   <= 1'b0;
      shift_q  <= '0;
      bit_cnt  <= '0;
      tx_idx   <= '0;
      gap_cnt  <= '0;
      snap     <= '0;
      ce_q     <= 1'b0;
      io_dir_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      sclk_d   <= bus.sclk;
      shift_q  <= shift_n;
      bit_cnt  <= bit_cnt_n;
      tx_idx   <= tx_idx_n;
      gap_cnt  <= gap_cnt_n;
      snap     <= snap_n;
      ce_q     <= ce_n;
      io_dir_q <= io_dir_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  // Pin-facing registers are updated on the transition into a state, so ce/IO/data are valid for the
  // whole LOAD cycle and a new bit is on the line one clk after each falling sclk edge.
  always_comb begin
    state_n   = state;
    shift_n   = shift_q;
    bit_cnt_n = bit_cnt;
    tx_idx_n  = tx_idx;
    gap_cnt_n = gap_cnt;
    snap_n    = snap;
    ce_n      = ce_q;
    io_dir_n  = io_dir_q;
    busy_n    = busy_q;
    done_n    = 1'b0;

    case (state)
      IDLE: begin
        // done_q blocks an en arriving in the same cycle as the completion pulse.
        if (bus.en && !done_q) begin
          state_n   = LOAD;
          snap_n    = {bus.yrIn, bus.dayIn, bus.monIn, bus.dateIn, bus.hrsIn, bus.minIn, bus.secIn};
          busy_n    = 1'b1;
          tx_idx_n  = 4'd0;
          bit_cnt_n = 4'd0;
          shift_n   = first_word;
          ce_n      = 1'b1;
          io_dir_n  = 1'b1;
        end
      end

      LOAD: state_n = SHIFT_H;

      SHIFT_H: begin
        if (rise) state_n = SHIFT_L;
      end

      SHIFT_L: begin
        if (fall) begin
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            state_n  = STOP;
            shift_n  = '0;
            ce_n     = 1'b0;
            io_dir_n = 1'b0;
          end else begin
            state_n = SHIFT_H;
            shift_n = {1'b0, shift_q[15:1]};
          end
        end
      end

      STOP: begin
        state_n   = GAP;
        gap_cnt_n = '0;
      end

      GAP: begin
        if (fall) begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt_n = '0;
            if (tx_idx == LAST_TX) begin
              state_n = IDLE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              state_n   = LOAD;
              tx_idx_n  = tx_idx + 4'd1;
              bit_cnt_n = 4'd0;
              shift_n   = next_word;
              ce_n      = 1'b1;
              io_dir_n  = 1'b1;
            end
          end else begin
            gap_cnt_n = gap_cnt + 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ds1302_write.sv
// Scoreboard bench for ds1302_write: a DS1302 bus model decodes each ce window and checks it against queued words.
`timescale 1ns/1ps
module tb_ds1302_write;

  localparam int GAP_EDGES = 2;
`ifdef DS1302_WP_RELOCK_EN
  localparam int NUM_TX = 9;
`else
  localparam int NUM_TX = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  ds1302_write_if bus();

  ds1302_write #(.GAP_EDGES(GAP_EDGES), .CTRL_ADDR(8'h8E)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // sclk toggles 2 ns after a negedge so it never coincides with a sampling edge.
  initial begin
    bus.sclk = 1'b0;
    #2;
    forever #40 bus.sclk = ~bus.sclk;
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  int          win_cnt = 0;
  int          done_cnt = 0;
  int          nrise = 0;
  int          seq_wins = 0;
  int          low_falls = 0;
  logic        sclk_p = 1'b0;
  logic        ce_p = 1'b0;
  logic        pend = 1'b0;
  logic        stab_valid = 1'b0;
  logic        stab_val = 1'b0;
  logic [15:0] rx = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // DS1302 model: counts only rises where ce was already high on the previous sample.
  always @(negedge clk) begin
    logic        rise, fall;
    logic [15:0] e;
    if (rst) begin
      ce_p       = 1'b0;
      pend       = 1'b0;
      stab_valid = 1'b0;
      nrise      = 0;
      low_falls  = 0;
      seq_wins   = 0;
      sclk_p     = bus.sclk;
    end else begin
      rise = bus.sclk && !sclk_p;
      fall = !bus.sclk && sclk_p;
      if (bus.done) done_cnt++;
      if (!bus.busy && !bus.ce) seq_wins = 0;
      if (fall && !ce_p) low_falls++;
      if (bus.ce && !ce_p) begin
        if (seq_wins > 0) check_output("gap_falls_ge_min", low_falls >= GAP_EDGES, 1);
        seq_wins++;
        win_cnt++;
        nrise      = 0;
        rx         = '0;
        pend       = 1'b0;
        stab_valid = 1'b0;
      end
      if (bus.ce && ce_p) begin
        if (rise) begin
          check_output("io_dir_high_at_rise", bus.ioDir, 1);
          if (stab_valid) check_output("data_stable_fall_to_rise", bus.dataOut, stab_val);
          stab_valid = 1'b0;
          if (nrise < 16) rx[nrise] = bus.dataOut;
          nrise++;
        end else if (pend) begin
          stab_val   = bus.dataOut;
          stab_valid = 1'b1;
          pend       = 1'b0;
        end
        if (fall) pend = 1'b1;
      end
      if (!bus.ce && ce_p) begin
        check_output("rises_per_tx", nrise, 16);
        check_output("tx_was_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_output("tx_cmd_data", {rx[7:0], rx[15:8]}, e);
        end
        low_falls  = 0;
        pend       = 1'b0;
        stab_valid = 1'b0;
      end
      ce_p   = bus.ce;
      sclk_p = bus.sclk;
    end
  end

  task automatic apply_stimulus(input logic [7:0] s, mi, h, d, mo, dy, y);
    @(negedge clk); #1;
    bus.secIn = s; bus.minIn = mi; bus.hrsIn = h; bus.dateIn = d;
    bus.monIn = mo; bus.dayIn = dy; bus.yrIn = y;
    exp_q.push_back({8'h8E, 8'h00});
    exp_q.push_back({8'h80, s});
    exp_q.push_back({8'h82, mi});
    exp_q.push_back({8'h84, h});
    exp_q.push_back({8'h86, d});
    exp_q.push_back({8'h88, mo});
    exp_q.push_back({8'h8A, dy});
    exp_q.push_back({8'h8C, y});
`ifdef DS1302_WP_RELOCK_EN
    exp_q.push_back({8'h8E, 8'h80});
`endif
    bus.en = 1'b1;
    @(negedge clk); #1;
    bus.en = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    bit ok;
    start = done_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt != start) begin
        ok = 1;
        break;
      end
    end
    check_output("done_within_budget", ok, 1);
  endtask

  task automatic wait_windows(input int target, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (win_cnt >= target) begin
        ok = 1;
        break;
      end
    end
    check_output("window_reached", ok, 1);
  endtask

  task automatic set_inputs_zero();
    bus.secIn = 8'h00; bus.minIn = 8'h00; bus.hrsIn = 8'h00; bus.dateIn = 8'h00;
    bus.monIn = 8'h00; bus.dayIn = 8'h00; bus.yrIn = 8'h00;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  base_w, base_d, bad;
    bit  ok;
    bus.en = 1'b0;
    set_inputs_zero();
    rst = 1'b1;

    repeat (3) @(negedge clk);
    check_output("reset_outputs", {bus.ce, bus.ioDir, bus.dataOut, bus.busy, bus.done}, 0);
    #1 rst = 1'b0;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ({bus.ce, bus.ioDir, bus.dataOut, bus.busy, bus.done} != 5'b0) bad++;
    end
    check_output("idle_nonzero_cycles", bad, 0);

    // Full write, then an en coinciding with done which must be ignored.
    base_w = win_cnt;
    base_d = done_cnt;
    apply_stimulus(8'h30, 8'h45, 8'h12, 8'h25, 8'h12, 8'h03, 8'h24);
    check_output("busy_after_en", bus.busy, 1);
    wait_done(4000);
    check_output("busy_low_at_done", bus.busy, 0);
    bus.en = 1'b1;
    @(negedge clk); #1;
    bus.en = 1'b0;
    check_output("done_one_clk_wide", bus.done, 0);
    repeat (300) @(negedge clk);
    check_output("windows_per_write", win_cnt - base_w, NUM_TX);
    check_output("done_pulses_write1", done_cnt - base_d, 1);
    check_output("en_with_done_ignored_busy", bus.busy, 0);
    check_output("queue_drained_write1", exp_q.size(), 0);

    // Inputs zeroed and en pulsed mid-write: snapshot must hold.
    base_w = win_cnt;
    base_d = done_cnt;
    apply_stimulus(8'h59, 8'h07, 8'h23, 8'h31, 8'h01, 8'h06, 8'h99);
    wait_windows(base_w + 3, 2000);
    set_inputs_zero();
    bus.en = 1'b1;
    @(negedge clk); #1;
    bus.en = 1'b0;
    wait_done(4000);
    repeat (300) @(negedge clk);
    check_output("windows_write2", win_cnt - base_w, NUM_TX);
    check_output("done_pulses_write2", done_cnt - base_d, 1);
    check_output("queue_drained_write2", exp_q.size(), 0);

    // Reset during bit 5 of transaction 3, then restart from transaction 0.
    base_w = win_cnt;
    base_d = done_cnt;
    apply_stimulus(8'h11, 8'h22, 8'h09, 8'h15, 8'h07, 8'h02, 8'h25);
    wait_windows(base_w + 4, 2000);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (nrise >= 5) begin
        ok = 1;
        break;
      end
    end
    check_output("reached_bit5", ok, 1);
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_output("rst_drops_ce_io_data", {bus.ce, bus.ioDir, bus.dataOut}, 0);
    check_output("rst_drops_busy", bus.busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    check_output("windows_before_abort", win_cnt - base_w, 4);
    check_output("no_done_on_abort", done_cnt - base_d, 0);

    base_w = win_cnt;
    base_d = done_cnt;
    apply_stimulus(8'h05, 8'h10, 8'h18, 8'h28, 8'h11, 8'h05, 8'h30);
    wait_done(4000);
    repeat (50) @(negedge clk);
    check_output("windows_after_restart", win_cnt - base_w, NUM_TX);
    check_output("done_pulses_restart", done_cnt - base_d, 1);
    check_output("queue_drained_restart", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
